// File: rtl/pipeline_pkg.sv
// pipeline_pkg: constants and types shared by the fetch-side sequencer and
// anything that needs to agree with it (fetch stage, testbench).
//   PC_STEP      - byte distance between sequential fetch addresses
//   RESET_PC_VAL - program counter value after reset
//   state_t      - fetch sequencer state (RUN / FLUSH)
package pipeline_pkg;

    localparam int          PC_STEP      = 4;
    localparam logic [31:0] RESET_PC_VAL = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear
//   en    - count this cycle
//   count - current value
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch-side PC sequencer.
// Redirects the PC on a taken branch from EX, squashes IF/ID and ID/EX for
// FLUSH_DEPTH cycles, then resumes sequential fetch throttled by Stall and
// IMemReady.
//   Clk, Rst_n        - clock, asynchronous active-low reset
//   PCSel, ExValid    - taken-branch decision from EX, qualified by ExValid
//   BranchTarget      - redirect address
//   Stall, IMemReady  - sequential-advance throttles
//   PC                - registered fetch address
//   FetchValid        - fetch request for PC this cycle
//   FlushIF, FlushID  - squash IF/ID and ID/EX
//   Redirecting       - high while flushing
//   TargetMisaligned  - sticky: some taken target had nonzero bits [1:0]
//   TakenCount        - saturating count of accepted taken branches
module pc_redirect_ctrl
    import pipeline_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(RESET_PC_VAL),
    parameter int               FLUSH_DEPTH = 2,   // legal 1..7
    parameter int               CNT_WIDTH   = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 PCSel,
    input  logic                 ExValid,
    input  logic [WIDTH-1:0]     BranchTarget,
    input  logic                 Stall,
    input  logic                 IMemReady,
    output logic [WIDTH-1:0]     PC,
    output logic                 FetchValid,
    output logic                 FlushIF,
    output logic                 FlushID,
    output logic                 Redirecting,
    output logic                 TargetMisaligned,
    output logic [CNT_WIDTH-1:0] TakenCount
);

    localparam int               FCW        = $clog2(FLUSH_DEPTH + 1);
    localparam logic [FCW-1:0]   FLUSH_LOAD = FCW'(FLUSH_DEPTH - 1);

    state_t         state;
    logic           run_en;
    logic [FCW-1:0] flush_cnt;
    logic           in_flush;
    logic           taken;

    assign in_flush = (state == FLUSH);
    // EX holds a bubble during FLUSH, so its PCSel is not a real branch.
    assign taken    = !in_flush && ExValid && PCSel;

    // run_en keeps the reset-exit cycle from issuing a fetch.
    assign FetchValid  = !in_flush && run_en && !Stall && IMemReady;
    assign FlushIF     = in_flush;
    assign FlushID     = in_flush;
    assign Redirecting = in_flush;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state            <= RUN;
            run_en           <= 1'b0;
            flush_cnt        <= '0;
            PC               <= RESET_PC;
            TargetMisaligned <= 1'b0;
        end else begin
            run_en <= 1'b1;
            case (state)
                RUN: begin
                    // Branch in EX is older than any stall source, so it wins.
                    if (taken) begin
                        PC               <= {BranchTarget[WIDTH-1:2], 2'b00};
                        flush_cnt        <= FLUSH_LOAD;
                        TargetMisaligned <= TargetMisaligned | (|BranchTarget[1:0]);
                        state            <= FLUSH;
                    end else if (FetchValid) begin
                        PC <= PC + WIDTH'(PC_STEP);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - FCW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_taken_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .en    (taken),
        .count (TakenCount)
    );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;
    import pipeline_pkg::*;

    localparam int WIDTH = 32;
    localparam int FD    = 2;
    localparam int CW    = 3;   // narrow so saturation is reachable

    logic             Clk, Rst_n, PCSel, ExValid, Stall, IMemReady;
    logic [WIDTH-1:0] BranchTarget, PC;
    logic             FetchValid, FlushIF, FlushID, Redirecting, TargetMisaligned;
    logic [CW-1:0]    TakenCount;

    int vectors = 0;
    int miscompares = 0;

    pc_redirect_ctrl #(
        .WIDTH(WIDTH), .RESET_PC(RESET_PC_VAL), .FLUSH_DEPTH(FD), .CNT_WIDTH(CW)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .PCSel(PCSel), .ExValid(ExValid),
        .BranchTarget(BranchTarget), .Stall(Stall), .IMemReady(IMemReady),
        .PC(PC), .FetchValid(FetchValid), .FlushIF(FlushIF), .FlushID(FlushID),
        .Redirecting(Redirecting), .TargetMisaligned(TargetMisaligned),
        .TakenCount(TakenCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic nstep();
        @(negedge Clk);
    endtask

    // Present a taken branch for one edge; returns at the negedge after it.
    task automatic do_branch(input logic [WIDTH-1:0] tgt);
        ExValid = 1'b1; PCSel = 1'b1; BranchTarget = tgt;
        nstep();
        ExValid = 1'b0; PCSel = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; PCSel = 1'b0; ExValid = 1'b0; BranchTarget = '0;
        Stall = 1'b0; IMemReady = 1'b1;
        nstep(); nstep();
        vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
        vectors++; if ({FetchValid, FlushIF, FlushID, Redirecting, TargetMisaligned} !== 5'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 00000", {FetchValid, FlushIF, FlushID, Redirecting, TargetMisaligned}); end
        vectors++; if (TakenCount !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", TakenCount); end
        Rst_n = 1'b1;
        #1;
        vectors++; if (FetchValid !== 1'b0) begin miscompares++; $display("FAIL exit_fv: got %b want 0", FetchValid); end
        nstep();
        vectors++; if (PC !== 32'h0 || FetchValid !== 1'b1) begin miscompares++; $display("FAIL first_fetch: got pc=%h fv=%b want pc=0 fv=1", PC, FetchValid); end
        for (int i = 1; i <= 4; i++) begin
            nstep();
            vectors++; if (PC !== 32'(i * 4)) begin miscompares++; $display("FAIL seq_pc%0d: got %h want %h", i, PC, 32'(i * 4)); end
        end
    endtask

    task automatic test_branch();
        // PC is 0x10 here
        do_branch(32'h40);
        vectors++; if (PC !== 32'h40) begin miscompares++; $display("FAIL br_pc: got %h want 40", PC); end
        vectors++; if ({FlushIF, FlushID, Redirecting, FetchValid} !== 4'b1110) begin miscompares++; $display("FAIL br_flush1: got %b want 1110", {FlushIF, FlushID, Redirecting, FetchValid}); end
        vectors++; if (TakenCount !== 3'd1) begin miscompares++; $display("FAIL br_count: got %0d want 1", TakenCount); end
        nstep();
        vectors++; if ({FlushIF, FlushID, Redirecting, FetchValid} !== 4'b1110 || PC !== 32'h40) begin miscompares++; $display("FAIL br_flush2: got %b pc=%h want 1110 pc=40", {FlushIF, FlushID, Redirecting, FetchValid}, PC); end
        nstep();
        vectors++; if ({FlushIF, FlushID, Redirecting, FetchValid} !== 4'b0001 || PC !== 32'h40) begin miscompares++; $display("FAIL br_resume: got %b pc=%h want 0001 pc=40", {FlushIF, FlushID, Redirecting, FetchValid}, PC); end
        nstep();
        vectors++; if (PC !== 32'h44) begin miscompares++; $display("FAIL br_next: got %h want 44", PC); end
    endtask

    task automatic test_stall_branch();
        Stall = 1'b1;
        do_branch(32'h80);
        vectors++; if (PC !== 32'h80 || FlushIF !== 1'b1) begin miscompares++; $display("FAIL st_redirect: got pc=%h fl=%b want pc=80 fl=1", PC, FlushIF); end
        vectors++; if (TakenCount !== 3'd2) begin miscompares++; $display("FAIL st_count: got %0d want 2", TakenCount); end
        nstep();
        vectors++; if (FlushID !== 1'b1) begin miscompares++; $display("FAIL st_flush2: got %b want 1", FlushID); end
        nstep();
        vectors++; if (FlushIF !== 1'b0 || FetchValid !== 1'b0 || PC !== 32'h80) begin miscompares++; $display("FAIL st_hold: got fl=%b fv=%b pc=%h want 0 0 80", FlushIF, FetchValid, PC); end
        nstep();
        vectors++; if (PC !== 32'h80) begin miscompares++; $display("FAIL st_hold2: got %h want 80", PC); end
        Stall = 1'b0;
        nstep();
        vectors++; if (PC !== 32'h84) begin miscompares++; $display("FAIL st_release: got %h want 84", PC); end
        // IMemReady low also holds the PC
        IMemReady = 1'b0;
        nstep();
        vectors++; if (PC !== 32'h84 || FetchValid !== 1'b0) begin miscompares++; $display("FAIL imem_hold: got pc=%h fv=%b want 84 0", PC, FetchValid); end
        IMemReady = 1'b1;
        // ExValid low: PCSel has no effect
        PCSel = 1'b1; BranchTarget = 32'h900;
        nstep();
        PCSel = 1'b0;
        vectors++; if (PC !== 32'h88 || FlushIF !== 1'b0 || TakenCount !== 3'd2) begin miscompares++; $display("FAIL exvalid_low: got pc=%h fl=%b cnt=%0d want 88 0 2", PC, FlushIF, TakenCount); end
    endtask

    task automatic test_misaligned();
        do_branch(32'h43);
        vectors++; if (PC !== 32'h40 || TargetMisaligned !== 1'b1) begin miscompares++; $display("FAIL mis_first: got pc=%h mis=%b want 40 1", PC, TargetMisaligned); end
        nstep(); nstep();
        do_branch(32'h100);
        vectors++; if (PC !== 32'h100 || TargetMisaligned !== 1'b1) begin miscompares++; $display("FAIL mis_sticky: got pc=%h mis=%b want 100 1", PC, TargetMisaligned); end
        vectors++; if (TakenCount !== 3'd4) begin miscompares++; $display("FAIL mis_count: got %0d want 4", TakenCount); end
        nstep(); nstep();
    endtask

    task automatic test_wrap();
        do_branch(32'hFFFF_FFF8);
        nstep(); nstep();
        vectors++; if (PC !== 32'hFFFF_FFF8 || FetchValid !== 1'b1) begin miscompares++; $display("FAIL wrap_start: got pc=%h fv=%b want fffffff8 1", PC, FetchValid); end
        nstep();
        vectors++; if (PC !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top: got %h want fffffffc", PC); end
        nstep();
        vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL wrap_zero: got %h want 00000000", PC); end
    endtask

    task automatic test_pcsel_in_flush();
        do_branch(32'h200);
        vectors++; if (TakenCount !== 3'd6) begin miscompares++; $display("FAIL fl_count0: got %0d want 6", TakenCount); end
        do_branch(32'h300);
        vectors++; if (PC !== 32'h200 || TakenCount !== 3'd6 || FlushIF !== 1'b1) begin miscompares++; $display("FAIL fl_ignore: got pc=%h cnt=%0d fl=%b want 200 6 1", PC, TakenCount, FlushIF); end
        nstep();
        vectors++; if (PC !== 32'h200 || FetchValid !== 1'b1 || FlushIF !== 1'b0) begin miscompares++; $display("FAIL fl_end: got pc=%h fv=%b fl=%b want 200 1 0", PC, FetchValid, FlushIF); end
    endtask

    task automatic test_reset_mid_flush();
        do_branch(32'h500);
        nstep();
        vectors++; if (Redirecting !== 1'b1 || TakenCount !== 3'd7) begin miscompares++; $display("FAIL rmf_pre: got red=%b cnt=%0d want 1 7", Redirecting, TakenCount); end
        Rst_n = 1'b0;
        #1;
        vectors++; if (PC !== 32'h0 || TakenCount !== 3'd0) begin miscompares++; $display("FAIL rmf_async: got pc=%h cnt=%0d want 0 0", PC, TakenCount); end
        vectors++; if ({FetchValid, FlushIF, FlushID, Redirecting, TargetMisaligned} !== 5'b0) begin miscompares++; $display("FAIL rmf_flags: got %b want 00000", {FetchValid, FlushIF, FlushID, Redirecting, TargetMisaligned}); end
        nstep();
        Rst_n = 1'b1;
        #1;
        vectors++; if (FetchValid !== 1'b0 || FlushIF !== 1'b0) begin miscompares++; $display("FAIL rmf_exit: got fv=%b fl=%b want 0 0", FetchValid, FlushIF); end
        nstep();
        vectors++; if (PC !== 32'h0 || FetchValid !== 1'b1 || FlushIF !== 1'b0) begin miscompares++; $display("FAIL rmf_restart: got pc=%h fv=%b fl=%b want 0 1 0", PC, FetchValid, FlushIF); end
        nstep();
        vectors++; if (PC !== 32'h4) begin miscompares++; $display("FAIL rmf_step: got %h want 4", PC); end
    endtask

    task automatic test_saturate();
        for (int i = 1; i <= 9; i++) begin
            do_branch(32'(i * 16));
            vectors++; if (TakenCount !== 3'((i > 7) ? 7 : i)) begin miscompares++; $display("FAIL sat_count%0d: got %0d want %0d", i, TakenCount, (i > 7) ? 7 : i); end
            nstep(); nstep();
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall_branch();
        test_misaligned();
        test_wrap();
        test_pcsel_in_flush();
        test_reset_mid_flush();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
